accum_pack: RTL
===============

ACCUM_PACK -- requirements
Module: accum_pack

Interface
REQ-001 SHALL have port: Clk  input  1  single clock; all state updates on falling edge of Clk.
REQ-002 SHALL have port: Reset  input  1  synchronous, active-high reset, sampled on falling edge of Clk.
REQ-003 SHALL have port: Y  input  4  data nibble from ALU stage.
REQ-004 SHALL have port: CBF  input  1  carry/borrow flag accompanying Y; used as carry-in.
REQ-005 SHALL have port: InValid  input  1  Y/CBF beat offered.
REQ-006 SHALL have port: InReady  output  1  block can accept a beat this cycle.
REQ-007 SHALL have port: Clear  input  1  synchronous accumulator clear.
REQ-008 SHALL have port: A  output  5  packed word at FIFO head, {sum[3:0], flag}.
REQ-009 SHALL have port: OutValid  output  1  A holds a valid word.
REQ-010 SHALL have port: OutReady  input  1  consumer takes A this cycle.
REQ-011 SHALL have port: Count  output  3  FIFO occupancy, 0..4.

Function
REQ-012 SHALL accept an input beat on a falling edge where InValid=1 and InReady=1; otherwise Y/CBF ignored.
REQ-013 SHALL keep a 4-bit accumulator ACC; per accepted beat compute S = ACC + Y + CBF (5-bit), load ACC <= S[3:0], push word {S[3:0], S[4]} into FIFO.
REQ-014 SHALL implement a 4-entry FIFO; A = head entry, OutValid = (Count != 0), A = 5'd0 when empty.
REQ-015 SHALL pop the head on a falling edge where OutValid=1 and OutReady=1.
REQ-016 SHALL drive InReady = (Count != 4), combinationally from registered occupancy only; no dependence on OutReady.
REQ-017 SHALL give one-edge latency: word pushed at edge N is visible on A with OutValid=1 immediately after edge N when FIFO was empty.
REQ-018 SHALL on simultaneous push and pop keep Count unchanged and preserve order; when Count=1, new word becomes head after the edge.
REQ-019 SHALL wrap read/write pointers modulo 4; no overwrite of unread entries, no pop from empty.
REQ-020 SHALL on Clear=1 set ACC <= 0; if a beat is accepted in the same edge, S is computed from ACC=0 and ACC <= S[3:0]; FIFO contents unaffected.
REQ-021 SHALL hold ACC when no beat accepted and Clear=0.

Reset
REQ-022 SHALL on Reset=1 at a falling edge set ACC=0, Count=0, pointers=0, OutValid=0, A=5'd0, InReady=1.
REQ-023 SHALL give Reset priority over Clear, push and pop; words in flight are discarded, beats offered during reset are not accepted.

Configuration
REQ-024 SHALL honour macro ACCUM_PACK_SAT_EN: when defined, if S[4]=1 then ACC <= 4'hF and pushed word = {4'hF, 1'b1}; when not defined, wrap-around per REQ-013.

Verification
REQ-025 SHALL cover: Reset, then beats Y=3/CBF=0, Y=4/CBF=1 with OutReady=1 -> A=5'b00110 then 5'b10000, OutValid each one edge after accept.
REQ-026 SHALL cover: ACC=4'hE, beat Y=4'h3/CBF=0 -> without macro A=5'b00011, ACC=1; with ACCUM_PACK_SAT_EN A=5'b11111, ACC=4'hF.
REQ-027 SHALL cover: OutReady=0, 5 consecutive beats -> Count 1,2,3,4, InReady=0 at Count=4, 5th beat not accepted; drain returns 4 words in order.
REQ-028 SHALL cover: Count=4, InValid=1, OutReady=1 -> pop only that edge (InReady=0), Count=3, next edge push+pop keeps Count=3.
REQ-029 SHALL cover: ACC=4'h9, Clear=1 with beat Y=2/CBF=1 -> A=5'b00110, ACC=3.
REQ-030 SHALL cover: Reset asserted with Count=3 and InValid=1 -> next edge Count=0, OutValid=0, A=0, ACC=0.

Source files
------------

// File: rtl/accum_pack.sv
// accum_pack: carry-chained nibble accumulator feeding a 4-entry output FIFO.
// Every accepted beat adds Y + CBF to a 4-bit accumulator and queues
// {sum[3:0], carry}. All state changes on the falling edge of Clk, and Reset
// is synchronous and active-high.
// Optional build macro ACCUM_PACK_SAT_EN: when it is defined, an overflowing
// sum saturates to 4'hF and queues {4'hF, 1'b1}. Otherwise the sum wraps.
module accum_pack (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Y,
    input  logic       CBF,
    input  logic       InValid,
    output logic       InReady,
    input  logic       Clear,
    output logic [4:0] A,
    output logic       OutValid,
    input  logic       OutReady,
    output logic [2:0] Count
);

    logic [3:0] acc;
    logic [4:0] mem [4];
    logic [1:0] wptr;
    logic [1:0] rptr;
    logic [2:0] count;

    logic       push;
    logic       pop;
    logic [3:0] acc_base;
    logic [4:0] sum;
    logic [3:0] acc_next;
    logic [4:0] word;

    // Handshake and head-of-FIFO outputs, derived only from registered occupancy
    always_comb begin
        InReady  = (count != 3'd4);
        OutValid = (count != 3'd0);
        A        = (count != 3'd0) ? mem[rptr] : '0;
        Count    = count;
        push     = InValid && (count != 3'd4);
        pop      = OutReady && (count != 3'd0);
    end

    // Next accumulator value and the word to queue; Clear zeroes the addend base
    always_comb begin
        acc_base = Clear ? '0 : acc;
        sum      = {1'b0, acc_base} + {1'b0, Y} + {4'b0000, CBF};
`ifdef ACCUM_PACK_SAT_EN
        if (sum[4]) begin
            acc_next = 4'hF;
            word     = {4'hF, 1'b1};
        end else begin
            acc_next = sum[3:0];
            word     = {sum[3:0], 1'b0};
        end
`else
        acc_next = sum[3:0];
        word     = {sum[3:0], sum[4]};
`endif
    end

    // Accumulator, FIFO storage, pointers and occupancy; reset overrides everything
    always_ff @(negedge Clk) begin
        if (Reset) begin
            acc   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                acc       <= acc_next;
                mem[wptr] <= word;
                wptr      <= wptr + 2'd1;
            end else if (Clear) begin
                acc <= '0;
            end
            if (pop) begin
                rptr <= rptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
